rgb_pwm_driver: RTL and testbench
=================================

// Module: rgb_pwm_driver
// PURPOSE
//  Downstream stage of the traffic-light decoder. Turns the six 8-bit colour intensities
//  (R1/G1/B1 for light 1, R2/G2/B2 for light 2) into six 1-bit PWM pins for the board's RGB LEDs.
//  Duties are latched once per PWM period, so a mid-period change from the decoder
//  (state change, btn flicker) never produces a runt or glitch pulse.
// PARAMETERS
//  PRESCALE    4  clk cycles per PWM phase step; legal range 1..65535.
//  ACTIVE_LOW  0  1 = invert all six pwm outputs (common-anode LED); the inactive level is then 1.
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active-high
//  en           in   1  1 = run PWM; 0 = outputs inactive, counters held at 0
//  R1_in..B2_in in   8  six intensity inputs, 0 = off, 255 = fully on; may change any cycle
//  R1_pwm..B2_pwm out 1 six PWM pins (R1,G1,B1,R2,G2,B2)
//  period_start out  1  1-cycle pulse when outputs first reflect phase 0 of a new period
// BEHAVIOUR
//  Reset (async, rst=1):
//   - presc=0, phase=0, all shadow duties=0.
//   - all pwm outputs at the inactive level (ACTIVE_LOW ? 1 : 0); period_start=0.
//  Prescaler:
//   - presc counts 0..PRESCALE-1 while en=1.
//   - tick = en && presc==PRESCALE-1; presc wraps to 0 on tick.
//   - PRESCALE=1: tick is high every cycle while en=1.
//  Phase:
//   - 8-bit phase counts 0..254 on tick, then wraps 254->0. Period = 255 phases = 255*PRESCALE clk.
//   - phase never takes the value 255.
//  Shadow load:
//   - On the tick that wraps phase 254->0, all six shadows <= *_in sampled that same clk edge.
//   - While en=0 the shadows load from *_in every cycle.
//   - *_in changes at any other time have no effect until the next wrap.
//  Compare:
//   - raw_x = (phase < shadow_x), unsigned 8-bit compare.
//   - duty 0 is never on; duty 255 is always on; duty d is on for d*PRESCALE clk of 255*PRESCALE.
//  Output register:
//   - x_pwm <= raw_x ^ ACTIVE_LOW. Outputs lag phase/shadow by exactly 1 clk.
//   - All six channels switch on the same edge, with no skew between them.
//  period_start:
//   - Registered. High for 1 clk on the edge after the wrap tick, i.e. the first cycle the
//     outputs show phase 0 with the new shadows.
//   - Not asserted on the first period after reset or after en rises.
//  en:
//   - en=0: presc=0, phase=0, outputs at the inactive level on the next edge, period_start=0.
//   - en 0->1: counting starts from phase 0 using the shadows loaded in the last en=0 cycle.
//     The first output cycle is phase 0 of a full period.
//  Simultaneous events:
//   - Wrap tick and *_in change on the same edge: the new *_in value is loaded.
//   - en falling on the wrap tick: en=0 wins. Counters go to 0, no period_start pulse.
//  Reset mid-period: outputs go inactive immediately (async). After release, behaviour is
//   identical to power-up.
//  Phase-to-output mapping (PRESCALE=1, duty d): x_pwm is active in the cycle after phase p
//   for every p < d.
// TESTING
//  T1 reset: rst=1 mid-period with all inputs 200
//     -> all pwm = inactive level and period_start=0 within the same cycle, before the next clk.
//  T2 PRESCALE=1, en=1, all inputs held at 0/255/128/1/254/64
//     -> per 255-clk period, active counts are 0/255/128/1/254/64;
//     -> period_start exactly every 255 clk.
//  T3 PRESCALE=4, R1_in=10
//     -> R1_pwm active 40 clk, inactive 980 clk; period 1020 clk.
//  T4 R1_in 50->200 at phase 100
//     -> that period still shows 50 active phases; the next period shows 200;
//     -> no extra pulse appears at the change point.
//  T5 ACTIVE_LOW=1, G2_in=0 and B2_in=255
//     -> G2_pwm constant 1, B2_pwm constant 0;
//     -> during reset and en=0 all pins read 1.
//  T6 en dropped at phase 30 for 5 clk, G1_in set to 77 meanwhile, en raised
//     -> outputs inactive from the next edge;
//     -> restart shows phase 0 with duty 77;
//     -> first period_start occurs 255*PRESCALE clk after restart.

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// Six-channel glitch-free RGB PWM driver for the two traffic lights.
// Duties are shadowed once per 255-phase period; outputs are registered.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE   = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] R1_in,
  input  logic [7:0] G1_in,
  input  logic [7:0] B1_in,
  input  logic [7:0] R2_in,
  input  logic [7:0] G2_in,
  input  logic [7:0] B2_in,
  output logic       R1_pwm,
  output logic       G1_pwm,
  output logic       B1_pwm,
  output logic       R2_pwm,
  output logic       G2_pwm,
  output logic       B2_pwm,
  output logic       period_start
);

  localparam logic [15:0] PMAX = 16'(PRESCALE - 1);
  localparam logic [5:0]  OFF  = {6{ACTIVE_LOW}};

  logic [15:0]     presc;
  logic [7:0]      phase;
  logic [5:0][7:0] shadow;
  logic [5:0][7:0] din;
  logic [5:0]      raw;
  logic [5:0]      pwm_q;
  logic            tick;
  logic            wrap;
  logic            wrap_q;

  assign din  = {B2_in, G2_in, R2_in, B1_in, G1_in, R1_in};
  assign tick = en && (presc == PMAX);
  assign wrap = tick && (phase == 8'd254);

  always_comb begin
    raw = '0;
    for (int c = 0; c < 6; c++) begin
      raw[c] = phase < shadow[c];
    end
  end

  // wrap_q delays the pulse so it lines up with the registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc        <= '0;
      phase        <= '0;
      shadow       <= '0;
      pwm_q        <= OFF;
      wrap_q       <= 1'b0;
      period_start <= 1'b0;
    end else if (!en) begin
      presc        <= '0;
      phase        <= '0;
      shadow       <= din;
      pwm_q        <= OFF;
      wrap_q       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      presc <= tick ? 16'd0 : presc + 16'd1;
      if (tick) begin
        phase <= wrap ? 8'd0 : phase + 8'd1;
      end
      if (wrap) begin
        shadow <= din;
      end
      pwm_q        <= raw ^ OFF;
      wrap_q       <= wrap;
      period_start <= wrap_q;
    end
  end

  assign R1_pwm = pwm_q[0];
  assign G1_pwm = pwm_q[1];
  assign B1_pwm = pwm_q[2];
  assign R2_pwm = pwm_q[3];
  assign G2_pwm = pwm_q[4];
  assign B2_pwm = pwm_q[5];

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: two instances (PRESCALE=1 active-high,
// PRESCALE=4 active-low) checked against an elapsed-time model.
module tb_rgb_pwm_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] in_v [6];
  logic [5:0] p1, p4;
  logic       ps1, ps4;

  int checks = 0;
  int errors = 0;
  int act [6];
  int nps;
  int edges;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(1), .ACTIVE_LOW(1'b0)) d1 (
    .clk(clk), .rst(rst), .en(en),
    .R1_in(in_v[0]), .G1_in(in_v[1]), .B1_in(in_v[2]),
    .R2_in(in_v[3]), .G2_in(in_v[4]), .B2_in(in_v[5]),
    .R1_pwm(p1[0]), .G1_pwm(p1[1]), .B1_pwm(p1[2]),
    .R2_pwm(p1[3]), .G2_pwm(p1[4]), .B2_pwm(p1[5]),
    .period_start(ps1)
  );

  rgb_pwm_driver #(.PRESCALE(4), .ACTIVE_LOW(1'b1)) d4 (
    .clk(clk), .rst(rst), .en(en),
    .R1_in(in_v[0]), .G1_in(in_v[1]), .B1_in(in_v[2]),
    .R2_in(in_v[3]), .G2_in(in_v[4]), .B2_in(in_v[5]),
    .R1_pwm(p4[0]), .G1_pwm(p4[1]), .B1_pwm(p4[2]),
    .R2_pwm(p4[3]), .G2_pwm(p4[4]), .B2_pwm(p4[5]),
    .period_start(ps4)
  );

  function automatic int pm(input int m);
    return (m == 0) ? 1 : 4;
  endfunction

  function automatic logic al(input int m);
    return (m == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [6:0] got(input int m);
    return (m == 0) ? {ps1, p1} : {ps4, p4};
  endfunction

  // Model: k = clocks elapsed since counting (re)started
  int unsigned k [2];
  logic [7:0]  sh [2][6];
  logic [6:0]  exp_v [2];
  int          per, pos, ph;

  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        k[m] = 0;
        for (int c = 0; c < 6; c++) sh[m][c] = 8'd0;
        exp_v[m] = {1'b0, {6{al(m)}}};
      end else if (!en) begin
        k[m] = 0;
        for (int c = 0; c < 6; c++) sh[m][c] = in_v[c];
        exp_v[m] = {1'b0, {6{al(m)}}};
      end else begin
        per = 255 * pm(m);
        pos = int'(k[m] % per);
        ph  = pos / pm(m);
        for (int c = 0; c < 6; c++)
          exp_v[m][c] = (ph < int'(sh[m][c])) ^ al(m);
        exp_v[m][6] = (k[m] != 0) && (pos == 0);
        if (pos == per - 1)
          for (int c = 0; c < 6; c++) sh[m][c] = in_v[c];
        k[m] = k[m] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (got(m) !== exp_v[m]) begin
        errors++;
        if (errors < 20)
          $display("FAIL model_d%0d t=%0t got %b want %b",
                   m, $time, got(m), exp_v[m]);
      end
    end
  end

  task automatic chk(input string nm, input int g, input int w);
    checks++;
    if (g != w) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, g, w);
    end
  endtask

  task automatic wait_ps(input int m, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (got(m)[6]) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_ps_d%0d got timeout want pulse", m);
    end
  endtask

  // Samples n consecutive negedges starting at the current one
  task automatic window(input int m, input int n, input int chg_at,
                        input logic [7:0] chg_val);
    logic [6:0] s;
    logic       prev;
    for (int c = 0; c < 6; c++) act[c] = 0;
    nps   = 0;
    edges = 0;
    prev  = got(m)[0] ^ al(m);
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) in_v[0] = chg_val;
      s = got(m);
      for (int c = 0; c < 6; c++)
        if (s[c] ^ al(m)) act[c]++;
      if (s[6]) nps++;
      if ((s[0] ^ al(m)) != prev) edges++;
      prev = s[0] ^ al(m);
      @(negedge clk);
    end
  endtask

  int t2 [6] = '{0, 255, 128, 1, 254, 64};

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    for (int c = 0; c < 6; c++) in_v[c] = 8'd200;
    repeat (3) @(negedge clk);
    chk("reset_d1", int'(got(0)), 'h00);
    chk("reset_d4", int'(got(1)), 'h3f);

    // Duty sweep at PRESCALE=1
    for (int c = 0; c < 6; c++) in_v[c] = t2[c][7:0];
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("en0_d4_inactive", int'(got(1)), 'h3f);
    en = 1'b1;
    wait_ps(0, 600);
    window(0, 255, -1, 8'd0);
    for (int c = 0; c < 6; c++) chk($sformatf("t2_act%0d", c), act[c], t2[c]);
    chk("t2_nps", nps, 1);
    chk("t2_ps_spacing", int'(ps1), 1);

    // PRESCALE=4 active-low: R1=10, G2 never on, B2 always on
    in_v[0] = 8'd10;
    in_v[4] = 8'd0;
    in_v[5] = 8'd255;
    wait_ps(1, 1100);
    wait_ps(1, 1100);
    window(1, 1020, -1, 8'd0);
    chk("t3_r1_act", act[0], 40);
    chk("t5_g2_act", act[4], 0);
    chk("t5_b2_act", act[5], 1020);
    chk("t3_nps", nps, 1);
    chk("t3_ps_spacing", int'(ps4), 1);

    // Mid-period duty change is deferred to the next period
    in_v[0] = 8'd50;
    wait_ps(0, 300);
    wait_ps(0, 300);
    window(0, 255, 100, 8'd200);
    chk("t4_old_act", act[0], 50);
    chk("t4_edges", edges, 1);
    window(0, 255, -1, 8'd0);
    chk("t4_new_act", act[0], 200);

    // en pause with duty change, restart from phase 0
    wait_ps(1, 1100);
    repeat (120) @(negedge clk);
    en = 1'b0;
    in_v[1] = 8'd77;
    repeat (5) @(negedge clk);
    chk("t6_off_d4", int'(got(1)), 'h3f);
    chk("t6_off_d1", int'(got(0)), 'h00);
    en = 1'b1;
    @(negedge clk);
    chk("t6_first_g1", int'(p4[1]), 0);
    window(1, 1020, -1, 8'd0);
    chk("t6_g1_act", act[1], 308);
    chk("t6_nps", nps, 0);
    chk("t6_first_ps", int'(ps4), 1);

    // Async reset mid-period
    @(posedge clk);
    #2;
    for (int c = 0; c < 6; c++) in_v[c] = 8'd200;
    rst = 1'b1;
    #1;
    chk("t1_async_d1", int'(got(0)), 'h00);
    chk("t1_async_d4", int'(got(1)), 'h3f);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
